// File: rtl/rx_fifo_drain_pkg.sv
// Shared constants for the Rx FIFO drain block: m_err bit positions and
// FIFO-word field offsets (relative to DATA_W).
package rx_fifo_drain_pkg;

    localparam int ERR_W   = 4;

    // m_err bit indices
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;
    localparam int ERR_OVR = 3;

    // FIFO word status-field offsets above the payload
    localparam int OFF_PAR = 0;
    localparam int OFF_FRM = 1;
    localparam int OFF_BRK = 2;
    localparam int OFF_OVR = 3;

    // ones = XOR of payload and parity bit; error when it disagrees with the selected sense
    function automatic logic parity_error(input logic en, input logic odd, input logic ones);
        return en & (ones != odd);
    endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry valid/ready output buffer. Head entry drives the output; entries
// shift on dequeue so ordering stays strictly FIFO.
module rx_skid_buf #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         deq;

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign deq       = out_valid & out_ready;

    // The producer never enqueues into a full buffer, so the 2'b10 case
    // with occ==2 cannot occur.
    // NOTE: the entries are reset even though they are storage: the output
    // data must read zero out of reset. State is updated with <= only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            unique case ({in_valid, deq})
                2'b10: begin
                    if (occ == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= in_data;
                    end else begin
                        head <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rx_fifo_drain.sv
// Drains UART words from the Rx FIFO into a valid/ready stream, checking parity,
// decoding line status and counting errored words.
module rx_fifo_drain
    import rx_fifo_drain_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int COUNT_W  = 8,
    parameter int DROP_ERR = 0
) (
    input  logic                    baud_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    rx_empty,
    input  logic [DATA_W+ERR_W-1:0] rx_rdata,
    output logic                    rx_pop,
    input  logic                    parity_en,
    input  logic                    parity_odd,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [ERR_W-1:0]        m_err,
    input  logic                    err_clr,
    output logic [COUNT_W-1:0]      err_cnt,
    output logic                    busy
);

    localparam int                 WORD_W  = DATA_W + ERR_W;
    localparam bit                 DROP    = (DROP_ERR != 0);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        occ;
    logic              infl;
    logic              cap;
    logic              deq;
    logic [2:0]        pending;
    logic [ERR_W-1:0]  cap_err;
    logic              cap_bad;
    logic              wr;
    logic [WORD_W-1:0] buf_data;

    // Slots already claimed after this cycle's dequeue; a pop needs one spare.
    assign deq     = m_valid & m_ready;
    assign pending = {1'b0, occ} + {2'b0, infl} - {2'b0, deq};
    assign rx_pop  = ~rst & enable & ~rx_empty & (pending < 3'd2);

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign infl = 1'b0;
            assign cap  = rx_pop;
        end else begin : g_lat1
            logic infl_q;
            always_ff @(posedge baud_clk or posedge rst) begin
                if (rst) infl_q <= 1'b0;
                else     infl_q <= rx_pop;
            end
            assign infl = infl_q;
            assign cap  = infl_q;
        end
    endgenerate

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cap_err          = '0;
        cap_err[ERR_PAR] = parity_error(parity_en, parity_odd,
                               ^{rx_rdata[DATA_W+OFF_PAR], rx_rdata[DATA_W-1:0]});
        cap_err[ERR_FRM] = rx_rdata[DATA_W+OFF_FRM];
        cap_err[ERR_BRK] = rx_rdata[DATA_W+OFF_BRK];
        cap_err[ERR_OVR] = rx_rdata[DATA_W+OFF_OVR];
    end

    assign cap_bad = |cap_err;
    assign wr      = cap & ~(DROP & cap_bad);

    rx_skid_buf #(
        .W (WORD_W)
    ) u_buf (
        .clk       (baud_clk),
        .rst       (rst),
        .in_valid  (wr),
        .in_data   ({cap_err, rx_rdata[DATA_W-1:0]}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (buf_data),
        .occ       (occ)
    );

    assign m_data = buf_data[DATA_W-1:0];
    assign m_err  = buf_data[WORD_W-1:DATA_W];
    assign busy   = infl | (occ != 2'd0);

    // A clear coinciding with a counted word leaves that word counted.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (cap & cap_bad) ? COUNT_W'(1) : '0;
        end else if (cap & cap_bad & (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_fifo_drain.sv
// Bench for rx_fifo_drain: instance A (RD_LAT=1, 8-bit count, keep errors) and
// instance B (RD_LAT=0, 2-bit count, drop errors), each fed by its own FIFO model.
module tb_rx_fifo_drain;
    import rx_fifo_drain_pkg::*;

    localparam int DW = 8;
    localparam int WW = DW + ERR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          en_a, empty_a, pop_a, pen_a, podd_a, mv_a, mr_a, clr_a, busy_a;
    logic [WW-1:0] rdata_a = '0;
    logic [DW-1:0] md_a;
    logic [3:0]    me_a;
    logic [7:0]    cnt_a;

    logic          en_b, empty_b, pop_b, pen_b, podd_b, mv_b, mr_b, clr_b, busy_b;
    logic [WW-1:0] rdata_b;
    logic [DW-1:0] md_b;
    logic [3:0]    me_b;
    logic [1:0]    cnt_b;

    rx_fifo_drain #(.DATA_W(DW), .RD_LAT(1), .COUNT_W(8), .DROP_ERR(0)) dut_a (
        .baud_clk(clk), .rst(rst), .enable(en_a), .rx_empty(empty_a), .rx_rdata(rdata_a),
        .rx_pop(pop_a), .parity_en(pen_a), .parity_odd(podd_a), .m_valid(mv_a),
        .m_ready(mr_a), .m_data(md_a), .m_err(me_a), .err_clr(clr_a), .err_cnt(cnt_a),
        .busy(busy_a));

    rx_fifo_drain #(.DATA_W(DW), .RD_LAT(0), .COUNT_W(2), .DROP_ERR(1)) dut_b (
        .baud_clk(clk), .rst(rst), .enable(en_b), .rx_empty(empty_b), .rx_rdata(rdata_b),
        .rx_pop(pop_b), .parity_en(pen_b), .parity_odd(podd_b), .m_valid(mv_b),
        .m_ready(mr_b), .m_data(md_b), .m_err(me_b), .err_clr(clr_b), .err_cnt(cnt_b),
        .busy(busy_b));

    // Rx FIFO models: A registers the head after a pop, B shows the head directly.
    logic [WW-1:0] mem_a [256];
    logic [WW-1:0] mem_b [256];
    logic [7:0]    wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;

    assign empty_a = (rd_a == wr_a);
    assign empty_b = (rd_b == wr_b);
    assign rdata_b = mem_b[rd_b];

    int cyc = 0, pops_a = 0, pops_b = 0, run_a = 0, last_a = -10;

    always @(posedge clk) begin
        cyc++;
        if (pop_a) begin
            run_a  = (last_a == cyc - 1) ? run_a + 1 : 1;
            last_a = cyc;
            pops_a++;
            rdata_a <= mem_a[rd_a];
            rd_a    <= rd_a + 8'd1;
        end
        if (pop_b) begin
            pops_b++;
            rd_b <= rd_b + 8'd1;
        end
    end

    // Output log: every accepted word, in acceptance order.
    logic [WW-1:0] obs_a [1024];
    logic [WW-1:0] obs_b [1024];
    int obs_n_a = 0, obs_n_b = 0;

    always begin
        @(negedge clk);
        #1;
        if (mv_a === 1'b1 && mr_a === 1'b1) begin obs_a[obs_n_a] = {me_a, md_a}; obs_n_a++; end
        if (mv_b === 1'b1 && mr_b === 1'b1) begin obs_b[obs_n_b] = {me_b, md_b}; obs_n_b++; end
    end

    // Reference model: expected output words and expected error count.
    logic [WW-1:0] exp_a [1024];
    logic [WW-1:0] exp_b [1024];
    int exp_n_a = 0, exp_n_b = 0, exp_cur_a = 0, exp_cur_b = 0;
    int obs_cur_a = 0, obs_cur_b = 0;
    int cnt_m_a = 0, cnt_m_b = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input logic [DW-1:0] data, input logic pbit,
                        input logic frm, input logic brk, input logic ovr);
        logic       pen, podd, perr;
        logic [3:0] err;
        pen  = (d == 0) ? pen_a  : pen_b;
        podd = (d == 0) ? podd_a : podd_b;
        perr = pen && (($countones({pbit, data}) % 2) != (podd ? 1 : 0));
        err  = {ovr, brk, frm, perr};
        if (d == 0) begin
            mem_a[wr_a] = {ovr, brk, frm, pbit, data};
            wr_a = wr_a + 8'd1;
            if (err != 4'd0) cnt_m_a = (cnt_m_a < 255) ? cnt_m_a + 1 : 255;
            exp_a[exp_n_a] = {err, data};
            exp_n_a++;
        end else begin
            mem_b[wr_b] = {ovr, brk, frm, pbit, data};
            wr_b = wr_b + 8'd1;
            if (err != 4'd0) cnt_m_b = (cnt_m_b < 3) ? cnt_m_b + 1 : 3;
            else begin
                exp_b[exp_n_b] = {err, data};
                exp_n_b++;
            end
        end
    endtask

    task automatic push_rand(input int d);
        push(d, DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    endtask

    function automatic logic idle(input int d);
        if (d == 0) return !busy_a && (empty_a || !en_a);
        return !busy_b && (empty_b || !en_b);
    endfunction

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        @(negedge clk);
        #2;
        while (!idle(d) && k < 300) begin
            @(negedge clk);
            #2;
            k++;
        end
        check($sformatf("idle_timeout_%0d", d), 32'(idle(d)), 32'(1));
        @(negedge clk);
    endtask

    // Compare the next k expected words against everything logged since the last call.
    task automatic score(input int d, input int k);
        int got;
        got = (d == 0) ? obs_n_a - obs_cur_a : obs_n_b - obs_cur_b;
        check($sformatf("word_count_%0d", d), 32'(got), 32'(k));
        for (int i = 0; i < k && i < got; i++) begin
            if (d == 0) check("word_a", 32'(obs_a[obs_cur_a + i]), 32'(exp_a[exp_cur_a + i]));
            else        check("word_b", 32'(obs_b[obs_cur_b + i]), 32'(exp_b[exp_cur_b + i]));
        end
        if (d == 0) begin obs_cur_a += got; exp_cur_a += k; end
        else        begin obs_cur_b += got; exp_cur_b += k; end
    endtask

    task automatic score_all(input int d);
        score(d, (d == 0) ? exp_n_a - exp_cur_a : exp_n_b - exp_cur_b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        en_a = 0; pen_a = 0; podd_a = 0; mr_a = 0; clr_a = 0;
        en_b = 0; pen_b = 0; podd_b = 0; mr_b = 0; clr_b = 0;
        tick(2);
        check("rst_pop_a",   32'(pop_a),  32'(0));
        check("rst_valid_a", 32'(mv_a),   32'(0));
        check("rst_data_a",  32'(md_a),   32'(0));
        check("rst_err_a",   32'(me_a),   32'(0));
        check("rst_cnt_a",   32'(cnt_a),  32'(0));
        check("rst_busy_a",  32'(busy_a), 32'(0));
        check("rst_valid_b", 32'(mv_b),   32'(0));
        check("rst_busy_b",  32'(busy_b), 32'(0));
        rst = 1'b0;
        tick(1);

        // Four even-parity words, consumer always ready.
        pen_a = 1; podd_a = 0; mr_a = 1; en_a = 1;
        p0 = pops_a;
        for (int i = 1; i <= 4; i++) push(0, 8'(17 * i), ^(8'(17 * i)), 0, 0, 0);
        wait_idle(0);
        check("t1_pops", 32'(pops_a - p0), 32'(4));
        check("t1_back_to_back", 32'(run_a), 32'(4));
        score_all(0);
        check("t1_cnt", 32'(cnt_a), 32'(cnt_m_a));

        // Stalled consumer: only two pops, head held stable.
        mr_a = 0;
        p0 = pops_a;
        for (int i = 1; i <= 5; i++) push(0, 8'(17 * i), ^(8'(17 * i)), 0, 0, 0);
        tick(8);
        check("t2_pops_stalled", 32'(pops_a - p0), 32'(2));
        for (int c = 0; c < 4; c++) begin
            check("t2_valid", 32'(mv_a), 32'(1));
            check("t2_hold",  32'(md_a), 32'(8'h11));
            tick(1);
        end
        mr_a = 1;
        wait_idle(0);
        check("t2_pops_all", 32'(pops_a - p0), 32'(5));
        score_all(0);

        // Parity error, then same word under odd parity.
        pen_a = 1; podd_a = 0;
        push(0, 8'h01, 1'b0, 0, 0, 0);
        wait_idle(0);
        score_all(0);
        check("t3_err_bits", 32'(obs_a[obs_n_a - 1][WW-1:DW]), 32'(4'b0001));
        check("t3_cnt", 32'(cnt_a), 32'(cnt_m_a));
        podd_a = 1;
        push(0, 8'h01, 1'b0, 0, 0, 0);
        wait_idle(0);
        score_all(0);
        check("t3_no_err", 32'(obs_a[obs_n_a - 1][WW-1:DW]), 32'(4'b0000));
        check("t3_cnt_held", 32'(cnt_a), 32'(cnt_m_a));

        // Random traffic on A: random consumer stalls and enable gaps.
        for (int b = 0; b < 6; b++) begin
            pen_a  = 1'($urandom_range(0, 1));
            podd_a = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) push_rand(0);
            for (int c = 0; c < 30; c++) begin
                mr_a = 1'($urandom_range(0, 1));
                en_a = ($urandom_range(0, 3) != 0);
                tick(1);
            end
            en_a = 1; mr_a = 1;
            wait_idle(0);
            score_all(0);
            check("rand_cnt_a", 32'(cnt_a), 32'(cnt_m_a));
        end

        // Enable drops one cycle after a pop: that word still arrives, no more pops.
        en_a = 0; pen_a = 0; mr_a = 1;
        for (int i = 0; i < 3; i++) push(0, 8'(8'hC0 + i), 1'b0, 0, 0, 0);
        en_a = 1;
        p0 = pops_a;
        tick(1);
        en_a = 0;
        tick(6);
        check("t6_one_pop", 32'(pops_a - p0), 32'(1));
        score(0, 1);

        // Reset mid-stream with a full buffer.
        mr_a = 0; en_a = 1;
        tick(3);
        check("t6_busy_before_rst", 32'(busy_a), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(mv_a),   32'(0));
        check("t6_rst_data",  32'(md_a),   32'(0));
        check("t6_rst_err",   32'(me_a),   32'(0));
        check("t6_rst_cnt",   32'(cnt_a),  32'(0));
        check("t6_rst_busy",  32'(busy_a), 32'(0));
        check("t6_rst_pop",   32'(pop_a),  32'(0));
        @(negedge clk);
        rst = 1'b0; en_a = 0;
        exp_cur_a = exp_n_a; obs_cur_a = obs_n_a; cnt_m_a = 0;
        tick(1);
        en_a = 1; mr_a = 1;
        push(0, 8'h7E, 1'b0, 0, 0, 0);
        push(0, 8'h81, 1'b0, 0, 0, 0);
        wait_idle(0);
        score_all(0);

        // Instance B: errored words dropped but counted.
        pen_b = 0; mr_b = 1; en_b = 1;
        push(1, 8'hA5, 1'b0, 1, 0, 0);
        push(1, 8'h5A, 1'b0, 0, 0, 0);
        wait_idle(1);
        score_all(1);
        check("t4_only_clean", 32'(obs_b[obs_n_b - 1]), 32'({4'b0000, 8'h5A}));
        check("t4_cnt", 32'(cnt_b), 32'(cnt_m_b));

        // Saturation, then clear together with an error word, then clear alone.
        for (int i = 0; i < 5; i++) push(1, DW'($urandom), 1'b0, 0, 0, 1);
        wait_idle(1);
        score_all(1);
        check("t5_saturate", 32'(cnt_b), 32'(cnt_m_b));
        clr_b = 1;
        push(1, 8'h3C, 1'b0, 0, 0, 1);
        cnt_m_b = 1;
        tick(1);
        clr_b = 0;
        wait_idle(1);
        check("t5_clr_with_err", 32'(cnt_b), 32'(cnt_m_b));
        clr_b = 1;
        tick(1);
        clr_b = 0;
        cnt_m_b = 0;
        tick(1);
        check("t5_clr_alone", 32'(cnt_b), 32'(cnt_m_b));

        // Random traffic on B.
        for (int b = 0; b < 6; b++) begin
            pen_b  = 1'($urandom_range(0, 1));
            podd_b = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) push_rand(1);
            for (int c = 0; c < 30; c++) begin
                mr_b = 1'($urandom_range(0, 1));
                en_b = ($urandom_range(0, 3) != 0);
                tick(1);
            end
            en_b = 1; mr_b = 1;
            wait_idle(1);
            score_all(1);
            check("rand_cnt_b", 32'(cnt_b), 32'(cnt_m_b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
